t05_sram_arbiter: RTL

Round-robin arbiter that shares the single Wishbone-style SRAM port between the compression-stage modules: histogram, find-least-value, Huffman tree, codebook synthesis and translation. Each stage issues single-word requests. The arbiter serializes them with one transaction outstanding at a time. It returns read data and a completion or error pulse to the winner, and aborts any transaction the memory fails to acknowledge within a bounded number of cycles. It sits between the stage modules and the SRAM interface, beside the top-level sequencing controller.

---
 rtl/t05_sram_arbiter_if.sv | 38 +++
 rtl/t05_sram_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/t05_sram_arbiter_if.sv
// Requester and SRAM-bus signal bundle for the shared SRAM arbiter.
// slave = arbiter view; master = stage modules plus memory view.
interface t05_sram_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*32-1:0] addr;
    logic [NREQ*32-1:0] wdata;
    logic [NREQ*4-1:0]  sel;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;
    logic [31:0]        rdata;
    logic               busy;
    logic [GW-1:0]      grant_id;
    logic               bus_cyc;
    logic               bus_stb;
    logic               bus_we;
    logic [31:0]        bus_adr;
    logic [31:0]        bus_dat_o;
    logic [3:0]         bus_sel;
    logic               bus_ack;
    logic [31:0]        bus_dat_i;

    modport slave (
        input  req, we, addr, wdata, sel, bus_ack, bus_dat_i,
        output done, err, rdata, busy, grant_id,
               bus_cyc, bus_stb, bus_we, bus_adr, bus_dat_o, bus_sel
    );

    modport master (
        output req, we, addr, wdata, sel, bus_ack, bus_dat_i,
        input  done, err, rdata, busy, grant_id,
               bus_cyc, bus_stb, bus_we, bus_adr, bus_dat_o, bus_sel
    );
endinterface

// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter serializing single-word stage requests onto one SRAM bus.
// Zero-wait read/write completes 2 cycles after grant sampling; no-ack aborts after TIMEOUT BUSY cycles.
module t05_sram_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    t05_sram_arbiter_if.slave       sif
);
    localparam int GW = $clog2(NREQ);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant_q;
    logic [31:0]     cnt;
    logic [NREQ-1:0] done_q;
    logic [NREQ-1:0] err_q;
    logic [31:0]     rdata_q;
    logic            cyc_q;
    logic            we_q;
    logic [31:0]     adr_q;
    logic [31:0]     dat_q;
    logic [3:0]      sel_q;

    logic            any_req;
    logic            found_hi, found_lo;
    logic [GW-1:0]   hi_idx, lo_idx, win_idx;
    logic            win_we;
    logic [31:0]     win_adr, win_dat;
    logic [3:0]      win_sel;
    logic            ack_hit, to_hit;

    // Round-robin: first requester above the last winner, else lowest at or below it.
    always_comb begin
        any_req  = |sif.req;
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_hi && sif.req[i] && (i > int'(grant_q))) begin
                found_hi = 1'b1;
                hi_idx   = GW'(i);
            end
            if (!found_lo && sif.req[i] && (i <= int'(grant_q))) begin
                found_lo = 1'b1;
                lo_idx   = GW'(i);
            end
        end
        win_idx = found_hi ? hi_idx : lo_idx;

        win_we  = 1'b0;
        win_adr = '0;
        win_dat = '0;
        win_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == GW'(i)) begin
                win_we  = sif.we[i];
                win_adr = sif.addr[32*i +: 32];
                win_dat = sif.wdata[32*i +: 32];
                win_sel = sif.sel[4*i +: 4];
            end
        end
    end

    assign ack_hit = sif.bus_ack;
    assign to_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = any_req ? BUSY : IDLE;
            BUSY:    state_nxt = (ack_hit || to_hit) ? RESP : BUSY;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= GW'(NREQ - 1);
            cnt     <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= win_idx;
                        cnt     <= '0;
                        cyc_q   <= 1'b1;
                        we_q    <= win_we;
                        adr_q   <= win_adr;
                        dat_q   <= win_dat;
                        sel_q   <= win_sel;
                    end
                end
                BUSY: begin
                    // Ack takes priority over a coincident timeout.
                    if (ack_hit) begin
                        rdata_q          <= we_q ? 32'd0 : sif.bus_dat_i;
                        cyc_q            <= 1'b0;
                        done_q[grant_q]  <= 1'b1;
                    end else if (to_hit) begin
                        rdata_q          <= 32'd0;
                        cyc_q            <= 1'b0;
                        err_q[grant_q]   <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sif.done      = done_q;
    assign sif.err       = err_q;
    assign sif.rdata     = rdata_q;
    assign sif.busy      = (state == BUSY) || (state == RESP);
    assign sif.grant_id  = grant_q;
    assign sif.bus_cyc   = cyc_q;
    assign sif.bus_stb   = cyc_q;
    assign sif.bus_we    = we_q;
    assign sif.bus_adr   = adr_q;
    assign sif.bus_dat_o = dat_q;
    assign sif.bus_sel   = sel_q;
endmodule
